id_stage_v: RTL and testbench
=============================

ID_STAGE_V -- requirements
Module: id_stage_v

Interface
REQ-001 Parameter NOP_INSTR, 32'h00000013, instruction value reported in id_instr for bubbles.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; asserted (0) sampled on clk edge resets the block.
REQ-004 is_valid, pc[31:0], instr[31:0]  in  1/32/32  fetch-stage outputs; instruction valid, its PC, its word.
REQ-005 is_flush  in  1  branch/jump redirect; kills instruction in decode.
REQ-006 ex_mem_read, ex_rd[4:0]  in  1/5  instruction currently in EX is a load, and its destination.
REQ-007 wb_we, wb_rd[4:0], wb_data[31:0]  in  1/5/32  register-file write port from writeback.
REQ-008 is_stall  out  1  combinational load-use stall request to fetch stage.
REQ-009 id_valid, id_pc[31:0], id_instr[31:0]  out  1/32/32  registered ID/EX valid, PC, instruction.
REQ-010 id_rs1_data, id_rs2_data, id_imm  out  32 each  registered operands and sign-extended immediate.
REQ-011 id_rs1, id_rs2, id_rd[4:0], id_funct3[2:0], id_funct7[6:0], id_opcode[6:0]  out  registered instruction fields.
REQ-012 id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump, id_illegal  out  1 each  registered control.

Function
REQ-013 Decode SHALL be combinational from instr; all id_* outputs SHALL register on the next clk edge (latency 1).
REQ-014 Register file SHALL hold 32 x 32-bit entries; x0 SHALL read 0; writes to x0 SHALL be ignored.
REQ-015 Writes SHALL occur on the rising edge when wb_we=1 and reset=1.
REQ-016 Immediate SHALL be built per RV32I format: I (0x13,0x03,0x67), S (0x23), B (0x63), U (0x37,0x17), J (0x6F); others 0.
REQ-017 Control SHALL decode: R 0x33 reg_write; I-ALU 0x13 reg_write,alu_src; load 0x03 reg_write,mem_read,alu_src; store 0x23 mem_write,alu_src; branch 0x63 branch; JAL/JALR jump,reg_write; LUI/AUIPC reg_write,alu_src.
REQ-018 Any other opcode with is_valid=1 SHALL set id_illegal=1, all other control 0, id_valid=1.
REQ-019 rs1 used by R, I-ALU, load, store, branch, JALR; rs2 used by R, store, branch.
REQ-020 is_stall SHALL equal is_valid & ~is_flush & ex_mem_read & (ex_rd!=0) & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
REQ-021 When is_stall=1 the next ID/EX value SHALL be a bubble: id_valid=0, all control 0, id_instr=NOP_INSTR, id_pc=0; decode re-evaluates the held instruction next cycle.
REQ-022 When is_flush=1 or is_valid=0 the next ID/EX value SHALL be a bubble; is_flush has priority over stall.
REQ-023 Register-file write and ID/EX capture in the same edge SHALL both take effect.

Reset
REQ-024 On reset all id_* outputs SHALL be bubble values (REQ-021) and id_imm, operand and field outputs 0.
REQ-025 On reset all 32 registers SHALL clear to 0 and a concurrent wb_we write SHALL be discarded.
REQ-026 Reset asserted mid-stall SHALL deassert is_stall only through its inputs; no internal stall state exists.

Configuration
REQ-027 Macro ID_BYPASS_EN defined: when wb_we=1, wb_rd!=0 and wb_rd equals rs1/rs2, id_rs1_data/id_rs2_data SHALL capture wb_data (write-first).
REQ-028 ID_BYPASS_EN undefined: operands SHALL capture the pre-write register contents (read-first); writeback forwarding is EX's responsibility.

Verification
REQ-029 Write x5=0xDEADBEEF, then instr 0x00528313 (addi x6,x5,5) valid -> next cycle id_rs1_data=0xDEADBEEF, id_imm=5, id_reg_write=1, id_alu_src=1.
REQ-030 ex_mem_read=1, ex_rd=5, instr add x7,x5,x6 valid -> is_stall=1, next id_valid=0; ex_rd=0 same case -> is_stall=0.
REQ-031 is_flush=1 with valid branch 0xFE000EE3 -> is_stall=0, next id_valid=0, id_branch=0, id_instr=0x00000013.
REQ-032 wb_we=1 wb_rd=5 wb_data=0x12345678 same cycle as read of x5 -> id_rs1_data=0x12345678 with ID_BYPASS_EN, prior value without.
REQ-033 wb write to x0 with 0xFFFFFFFF, then read x0 -> id_rs1_data=0; reset=0 for one edge -> all registers read 0, id_valid=0.
REQ-034 Instr 0x0000007F valid -> id_illegal=1, id_valid=1, other control 0; jal x1,-8 (0xFF9FF0EF) -> id_imm=0xFFFFFFF8, id_jump=1.

Source files
------------

// File: rtl/id_stage_v.sv
// id_stage_v: RV32I decode stage with register file, load-use stall and ID/EX register.
// Ports: clk, reset (sync, active-low); is_valid/pc/instr/is_flush from fetch;
//   ex_mem_read/ex_rd from EX; wb_we/wb_rd/wb_data register-file write port;
//   is_stall (comb) to fetch; id_* registered ID/EX bundle.
// Macro ID_BYPASS_EN: write-first operand read from the writeback port.
module id_stage_v #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        is_flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        is_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [6:0]  id_opcode,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_alu_src,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal
);

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_IALU  = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    logic [31:0] r_rf [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_rw, w_mr, w_mw, w_as, w_br, w_jp, w_ill;
    logic        w_use1, w_use2;
    logic        w_bubble;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    assign w_opcode = instr[6:0];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];

    always_comb begin
        w_imm  = '0;
        w_rw   = 1'b0;
        w_mr   = 1'b0;
        w_mw   = 1'b0;
        w_as   = 1'b0;
        w_br   = 1'b0;
        w_jp   = 1'b0;
        w_ill  = 1'b0;
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_rw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
            end
            OP_IALU: begin
                w_rw = 1'b1; w_as = 1'b1; w_use1 = 1'b1;
                w_imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                w_rw = 1'b1; w_mr = 1'b1; w_as = 1'b1; w_use1 = 1'b1;
                w_imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                w_mw = 1'b1; w_as = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
                w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BR: begin
                w_br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
                w_imm = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                w_jp = 1'b1; w_rw = 1'b1;
                w_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            end
            OP_JALR: begin
                w_jp = 1'b1; w_rw = 1'b1; w_use1 = 1'b1;
                w_imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                w_rw = 1'b1; w_as = 1'b1;
                w_imm = {instr[31:12], 12'b0};
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Stall is purely a function of current inputs; no stall state is kept.
    assign is_stall = is_valid & ~is_flush & ex_mem_read & (ex_rd != 5'd0)
                    & ((w_use1 & (w_rs1 == ex_rd)) | (w_use2 & (w_rs2 == ex_rd)));

    assign w_bubble = ~is_valid | is_flush | is_stall;

`ifdef ID_BYPASS_EN
    // Write-first: a same-cycle writeback to the source wins over the array.
    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                        (wb_we && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                        (wb_we && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];
`else
    // Read-first: EX forwards the writeback value itself.
    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || w_bubble) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_instr     <= NOP_INSTR;
            id_rs1_data  <= '0;
            id_rs2_data  <= '0;
            id_imm       <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_funct3    <= '0;
            id_funct7    <= '0;
            id_opcode    <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_alu_src   <= 1'b0;
            id_branch    <= 1'b0;
            id_jump      <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            id_valid     <= 1'b1;
            id_pc        <= pc;
            id_instr     <= instr;
            id_rs1_data  <= w_rs1_data;
            id_rs2_data  <= w_rs2_data;
            id_imm       <= w_imm;
            id_rs1       <= w_rs1;
            id_rs2       <= w_rs2;
            id_rd        <= instr[11:7];
            id_funct3    <= instr[14:12];
            id_funct7    <= instr[31:25];
            id_opcode    <= w_opcode;
            id_reg_write <= w_rw;
            id_mem_read  <= w_mr;
            id_mem_write <= w_mw;
            id_alu_src   <= w_as;
            id_branch    <= w_br;
            id_jump      <= w_jp;
            id_illegal   <= w_ill;
        end
    end

endmodule

// File: tb/tb_id_stage_v.sv
// tb_id_stage_v: directed and random checks of id_stage_v against a
// behavioural model (register array, arithmetic immediates, opcode table).
module tb_id_stage_v;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, is_valid, is_flush, ex_mem_read, wb_we;
    logic [31:0] pc, instr, wb_data;
    logic [4:0]  ex_rd, wb_rd;
    logic        is_stall, id_valid;
    logic [31:0] id_pc, id_instr, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7, id_opcode;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic        id_branch, id_jump, id_illegal;

    id_stage_v #(.NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .reset(reset), .is_valid(is_valid), .pc(pc),
        .instr(instr), .is_flush(is_flush), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .is_stall(is_stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .id_opcode(id_opcode),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] rf [32];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit uses1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    // {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal}
    function automatic logic [6:0] ctrl_of(input logic [6:0] op);
        case (op)
            7'h33:        return 7'b1000000;
            7'h13:        return 7'b1001000;
            7'h03:        return 7'b1101000;
            7'h23:        return 7'b0011000;
            7'h63:        return 7'b0000100;
            7'h6F, 7'h67: return 7'b1000010;
            7'h37, 7'h17: return 7'b1001000;
            default:      return 7'b0000001;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        int v;
        int neg;
        neg = w[31] ? 1 : 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: v = (w >> 20) - neg * 4096;
            7'h23: v = ((w >> 25) << 5) + ((w >> 7) & 31) - neg * 4096;
            7'h63: v = ((w >> 8) & 15) * 2 + ((w >> 25) & 63) * 32
                     + ((w >> 7) & 1) * 2048 - neg * 4096;
            7'h6F: v = ((w >> 21) & 1023) * 2 + ((w >> 20) & 1) * 2048
                     + ((w >> 12) & 255) * 4096 - neg * (1 << 20);
            7'h37, 7'h17: v = w & 32'hFFFFF000;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rd_model(input int r);
        if (r == 0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (wb_we && wb_rd == r[4:0]) return wb_data;
`endif
        return rf[r];
    endfunction

    task automatic cycle();
        logic [6:0]  op;
        int          r1, r2;
        bit          stl, bub, rst;
        logic [31:0] e_pc, e_in, e_d1, e_d2, e_imm, e_fld;
        logic [6:0]  e_ctl;
        #1;
        op  = instr[6:0];
        r1  = (instr >> 15) & 31;
        r2  = (instr >> 20) & 31;
        stl = is_valid && !is_flush && ex_mem_read && ex_rd != 0 &&
              ((uses1(op) && r1 == ex_rd) || (uses2(op) && r2 == ex_rd));
        chk("is_stall", {31'd0, is_stall}, {31'd0, stl});
        rst   = !reset;
        bub   = rst || !is_valid || is_flush || stl;
        e_pc  = bub ? 32'd0 : pc;
        e_in  = bub ? 32'h00000013 : instr;
        e_ctl = bub ? 7'd0 : ctrl_of(op);
        e_d1  = rd_model(r1);
        e_d2  = rd_model(r2);
        e_imm = imm_of(instr);
        e_fld = {instr[19:15], instr[24:20], instr[11:7], instr[14:12],
                 instr[31:25], op};
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else if (wb_we && wb_rd != 0) begin
            rf[wb_rd] = wb_data;
        end
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, !bub});
        chk("id_pc", id_pc, e_pc);
        chk("id_instr", id_instr, e_in);
        chk("id_ctrl", {25'd0, id_reg_write, id_mem_read, id_mem_write,
            id_alu_src, id_branch, id_jump, id_illegal}, {25'd0, e_ctl});
        if (rst) begin
            chk("rst_imm", id_imm, 32'd0);
            chk("rst_rs1d", id_rs1_data, 32'd0);
            chk("rst_rs2d", id_rs2_data, 32'd0);
            chk("rst_fld", {id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
                id_opcode}, 32'd0);
        end else if (!bub) begin
            chk("id_imm", id_imm, e_imm);
            chk("id_rs1_data", id_rs1_data, e_d1);
            chk("id_rs2_data", id_rs2_data, e_d2);
            chk("id_fields", {id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
                id_opcode}, e_fld);
        end
    endtask

    task automatic idle();
        is_valid = 0; is_flush = 0; ex_mem_read = 0; ex_rd = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        logic [6:0] ops [11];
        logic [6:0] op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                7'h37, 7'h17, 7'h7F, 7'h73};
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        reset = 0; pc = 32'h100; instr = 32'h00000013;
        idle();
        cycle();
        cycle();
        reset = 1;

        // write x5, then addi x6,x5,5
        wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        cycle();
        idle(); is_valid = 1; pc = 32'h104; instr = 32'h00528313;
        cycle();
        chk("addi_rs1", id_rs1_data, 32'hDEADBEEF);
        chk("addi_imm", id_imm, 32'd5);
        chk("addi_rw", {31'd0, id_reg_write}, 32'd1);
        chk("addi_as", {31'd0, id_alu_src}, 32'd1);

        // load-use on add x7,x5,x6
        instr = 32'h006283B3; ex_mem_read = 1; ex_rd = 5;
        #1 chk("lu_stall", {31'd0, is_stall}, 32'd1);
        cycle();
        chk("lu_valid", {31'd0, id_valid}, 32'd0);
        ex_rd = 0;
        #1 chk("lu_rd0", {31'd0, is_stall}, 32'd0);
        cycle();
        chk("lu_rd0_valid", {31'd0, id_valid}, 32'd1);

        // flush beats everything
        instr = 32'hFE000EE3; is_flush = 1;
        cycle();
        chk("fl_valid", {31'd0, id_valid}, 32'd0);
        chk("fl_br", {31'd0, id_branch}, 32'd0);
        chk("fl_instr", id_instr, 32'h00000013);

        // same-edge write and read of x5
        idle(); is_valid = 1; instr = 32'h00528313;
        wb_we = 1; wb_rd = 5; wb_data = 32'h12345678;
        cycle();
`ifdef ID_BYPASS_EN
        chk("byp_rs1", id_rs1_data, 32'h12345678);
`else
        chk("byp_rs1", id_rs1_data, 32'hDEADBEEF);
`endif

        // x0 stays zero
        idle(); wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        cycle();
        idle(); is_valid = 1; instr = 32'h00000313;
        cycle();
        chk("x0_read", id_rs1_data, 32'd0);

        // reset clears registers and drops a concurrent write
        reset = 0; wb_we = 1; wb_rd = 9; wb_data = 32'hA5A5A5A5;
        is_valid = 1; instr = 32'h00528313;
        cycle();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        reset = 1; idle(); is_valid = 1; instr = 32'h00528313;
        cycle();
        chk("rst_x5", id_rs1_data, 32'd0);
        instr = 32'h00048313;
        cycle();
        chk("rst_x9", id_rs1_data, 32'd0);

        // illegal and jal
        instr = 32'h0000007F;
        cycle();
        chk("ill", {31'd0, id_illegal}, 32'd1);
        chk("ill_valid", {31'd0, id_valid}, 32'd1);
        instr = 32'hFF9FF0EF;
        cycle();
        chk("jal_imm", id_imm, 32'hFFFFFFF8);
        chk("jal_jump", {31'd0, id_jump}, 32'd1);

        // random traffic
        repeat (600) begin
            op = ops[$urandom_range(0, 10)];
            instr = ($urandom() & 32'hFFFFFF80) | {25'd0, op};
            pc = $urandom() & 32'hFFFFFFFC;
            reset = ($urandom_range(0, 49) != 0);
            is_valid = ($urandom_range(0, 4) != 0);
            is_flush = ($urandom_range(0, 9) == 0);
            ex_mem_read = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: ex_rd = instr[19:15];
                1: ex_rd = instr[24:20];
                default: ex_rd = 5'($urandom());
            endcase
            wb_we = $urandom_range(0, 1);
            wb_rd = ($urandom_range(0, 2) == 0) ? instr[19:15] : 5'($urandom());
            wb_data = $urandom();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
